mem_bus_unit: RTL
=================

Name: mem_bus_unit

Overview:
- Downstream stage of the CPU control FSM; consumes its memory-side controls (load_pc, reset_pc, addr_sel, load_addr, mem_cmd) plus datapath result C.
- Holds the program counter and data-address register, selects the bus address, and runs bus transactions.
- Targets: a variable-latency RAM (ready handshake) and memory-mapped I/O (LED register, switch port).
- Returns read data for the instruction register and register-file writeback, and raises mem_busy so control can stall.

Parameters:
- ADDR_W, 9, bus address width (PC and data address).
- RAM_AW, 8, RAM word-address width; RAM occupies addresses 0x000-0x0FF.
- LED_ADDR, 9'h100, write-only LED register address.
- SW_ADDR, 9'h140, read-only switch port address.
- TIMEOUT, 15, maximum cycles spent in WAIT before abort; 4-bit counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- load_pc  in  1  PC update enable.
- reset_pc  in  1  with load_pc, PC <- 0.
- addr_sel  in  1  1: mem_addr = PC; 0: mem_addr = data address.
- load_addr  in  1  data address <- datapath_out[8:0].
- mem_cmd  in  2  00 none, 11 read, 01 write, 10 reserved (treated as none).
- datapath_out  in  16  C register: address source and write data.
- sw  in  8  switch inputs.
- ram_rdata  in  16  RAM read data, valid when ram_ready=1.
- ram_ready  in  1  RAM completes the current access.
- mem_addr  out  9  selected bus address.
- pc_out  out  9  current PC.
- read_data  out  16  registered read result.
- ram_re  out  1  RAM read request.
- ram_we  out  1  RAM write request.
- ram_addr  out  8  RAM word address.
- ram_wdata  out  16  RAM write data.
- led_out  out  8  LED register.
- mem_busy  out  1  transaction in progress; control must hold its state.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): pc, data address, read_data, led_out, bus_err, timeout counter <- 0; state <- IDLE; ram_re = ram_we = 0.
- PC register:
  - load_pc && reset_pc: pc <- 0.
  - load_pc only: pc <- pc+1, wrapping 0x1FF -> 0x000.
  - Otherwise pc holds.
- Data address: load_addr: addr <- datapath_out[8:0].
- mem_addr is combinational from addr_sel.
- Decode, on mem_addr:
  - RAM when mem_addr[8]=0.
  - LED when mem_addr == LED_ADDR.
  - SW when mem_addr == SW_ADDR.
  - Anything else is unmapped.
- FSM states: IDLE, WAIT, DONE.
- IDLE, command active (mem_cmd in {11, 01}):
  - RAM target: capture target address and latch write data (datapath_out) into ram_wdata; -> WAIT.
  - LED write: led_out <- datapath_out[7:0]; -> DONE.
  - SW read: read_data <- {8'h00, sw}; -> DONE.
  - LED read: read_data <- {8'h00, led_out}; -> DONE.
  - SW write: ignored; -> DONE.
  - Unmapped target: bus_err <- 1; reads give read_data <- 0; -> DONE.
  - MMIO and unmapped accesses therefore complete at the same edge they are seen.
- WAIT:
  - ram_re (read) or ram_we (write) is held high; ram_addr and ram_wdata are stable.
  - ram_ready=1: read_data <- ram_rdata (reads only); -> DONE; counter cleared.
  - Otherwise the counter increments. If the counter reaches TIMEOUT without ram_ready: bus_err <- 1, read_data <- 0, -> DONE.
- DONE:
  - ram_re = ram_we = 0.
  - Stay while mem_cmd and mem_addr are unchanged from the captured values; this prevents repeated writes while control holds mem_cmd across states.
  - -> IDLE when mem_cmd becomes none or the address/command changes.
  - The new command is evaluated in IDLE on the following cycle.
- mem_busy = (state==WAIT) | (state==IDLE && command active && RAM target).
- Latency:
  - Zero-wait RAM (ram_ready high on the first WAIT cycle): read_data is valid 2 edges after the command appears.
  - MMIO: read_data is valid 1 edge after the command appears.
- read_data holds its value until the next completed read.
- ram_ready outside WAIT is ignored.
- bus_err is cleared only by reset.
- Asynchronous reset during WAIT aborts the access: ram_re/ram_we drop immediately, and no write or read capture occurs.

Test Plan:
- Reset, then load_pc=1 for 3 cycles, then load_pc=1 + reset_pc=1 -> pc_out 0,1,2,3 then 0; PC set to 0x1FF plus load_pc -> 0x000.
- addr_sel=1, mem_cmd=11, pc=5, ram_ready high on the 3rd WAIT cycle with rdata 16'hABCD -> ram_re high for 3 cycles at ram_addr 0x05, mem_busy high for 4 cycles, read_data = 16'hABCD.
- load_addr with C = 16'h0100, then mem_cmd=01 with C = 16'h005A held 3 cycles -> led_out = 8'h5A after 1 edge, a single write, ram_we never asserted.
- sw = 8'h3C, data address 0x140, mem_cmd=11 -> read_data = 16'h003C next edge, mem_busy never high.
- RAM write to 0x10 with ram_ready held low -> ram_we high for TIMEOUT cycles, then bus_err=1, state DONE, mem_busy low.
- Access to unmapped 0x180, then reset pulsed low mid-WAIT of a RAM read -> bus_err=1 after the access; on reset all outputs are 0 immediately and ram_re drops asynchronously.

Source files
------------

// File: rtl/mem_bus_unit_if.sv
// RAM-side bus of the memory/bus unit: request, address, write data, ready/read-data return.
// No storage; pure wiring bundle.
// The unit (master) holds its request until the RAM (slave) raises ram_ready.
interface mem_bus_unit_if #(
  parameter int RAM_AW = 8
);
  logic              ram_re;
  logic              ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic              ram_ready;

  modport master (
    output ram_re, ram_we, ram_addr, ram_wdata,
    input  ram_rdata, ram_ready
  );

  modport slave (
    input  ram_re, ram_we, ram_addr, ram_wdata,
    output ram_rdata, ram_ready
  );
endinterface

// File: rtl/mem_bus_unit.sv
// PC / data-address holder and bus sequencer for RAM and MMIO (LED register, switch port).
// MMIO/unmapped: result 1 edge after the command; RAM: 2 edges minimum, plus RAM wait cycles.
// Holds ram_re/ram_we until ram_ready or a 15-cycle timeout; mem_busy stalls the control FSM.
module mem_bus_unit #(
  parameter int                 ADDR_W   = 9,
  parameter int                 RAM_AW   = 8,
  parameter logic [ADDR_W-1:0]  LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0]  SW_ADDR  = 9'h140,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              addr_sel,
  input  logic              load_addr,
  input  logic [1:0]        mem_cmd,
  input  logic [15:0]       datapath_out,
  input  logic [7:0]        sw,
  mem_bus_unit_if.master    ram,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       read_data,
  output logic [7:0]        led_out,
  output logic              mem_busy,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] CMD_RD = 2'b11;
  localparam logic [1:0] CMD_WR = 2'b01;
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [7:0]         led_q, led_d;
  logic               err_q, err_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [1:0]         cap_cmd_q, cap_cmd_d;
  logic [ADDR_W-1:0]  cap_addr_q, cap_addr_d;
  logic [15:0]        wdata_q, wdata_d;

  logic cmd_active;
  logic cmd_is_rd;
  logic tgt_ram;
  logic tgt_led;
  logic tgt_sw;

  // Address mux and target decode of the live bus address
  always_comb begin
    mem_addr   = addr_sel ? pc_q : addr_q;
    cmd_active = (mem_cmd == CMD_RD) || (mem_cmd == CMD_WR);
    cmd_is_rd  = (mem_cmd == CMD_RD);
    tgt_ram    = (mem_addr[ADDR_W-1:RAM_AW] == '0);
    tgt_led    = (mem_addr == LED_ADDR);
    tgt_sw     = (mem_addr == SW_ADDR);
  end

  // Next-state logic: PC, data address, and the IDLE/WAIT/DONE transaction sequencer
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    led_d      = led_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cap_cmd_d  = cap_cmd_q;
    cap_addr_d = cap_addr_q;
    wdata_d    = wdata_q;

    if (load_pc) begin
      pc_d = reset_pc ? '0 : pc_q + 1'b1;
    end
    if (load_addr) begin
      addr_d = datapath_out[ADDR_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_active) begin
          cap_cmd_d  = mem_cmd;
          cap_addr_d = mem_addr;
          if (tgt_ram) begin
            wdata_d = datapath_out;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            // MMIO and unmapped targets finish on this edge
            state_d = S_DONE;
            if (tgt_led) begin
              if (cmd_is_rd) rdata_d = {8'h00, led_q};
              else           led_d   = datapath_out[7:0];
            end else if (tgt_sw) begin
              if (cmd_is_rd) rdata_d = {8'h00, sw};
            end else begin
              err_d = 1'b1;
              if (cmd_is_rd) rdata_d = '0;
            end
          end
        end
      end

      S_WAIT: begin
        if (ram.ram_ready) begin
          if (cap_cmd_q == CMD_RD) rdata_d = ram.ram_rdata;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // RAM never answered: abort with an error and a zero result
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // Wait for control to drop or change the command so a held command is not replayed
        if ((mem_cmd != cap_cmd_q) || (mem_addr != cap_addr_q)) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset mid-access abandons it with no capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      led_q      <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cap_cmd_q  <= '0;
      cap_addr_q <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      led_q      <= led_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cap_cmd_q  <= cap_cmd_d;
      cap_addr_q <= cap_addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Output drive; RAM strobes come straight from state so reset drops them at once
  always_comb begin
    pc_out        = pc_q;
    read_data     = rdata_q;
    led_out       = led_q;
    bus_err       = err_q;
    ram.ram_re    = (state_q == S_WAIT) && (cap_cmd_q == CMD_RD);
    ram.ram_we    = (state_q == S_WAIT) && (cap_cmd_q == CMD_WR);
    ram.ram_addr  = cap_addr_q[RAM_AW-1:0];
    ram.ram_wdata = wdata_q;
    mem_busy      = (state_q == S_WAIT) || ((state_q == S_IDLE) && cmd_active && tgt_ram);
  end

endmodule
